// File: rtl/vpu_tile_responder.sv
// Datapath-side responder to the VPU controller strobes: operand read addressing, result stores, writeback beats.
// Define VPU_RESP_ERRCHK_EN to build the strobe-protocol checker (err_len / err_overlap).
module vpu_tile_responder #(
    parameter int unsigned DW            = 16,
    parameter int unsigned ROW_A         = 4,
    parameter int unsigned COL_A         = 4,
    parameter int unsigned ROW_W         = 4,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned TILES_PER_ROW = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          compute,
    input  logic                                          load_a,
    input  logic                                          load_w,
    input  logic                                          deload,
    input  logic                                          store,
    input  logic                                          deload_out,
    input  logic                                          reset_sys,
    input  logic [DW*ROW_A-1:0]                           res_in,
    input  logic                                          err_clr,
    output logic                                          a_rd_en,
    output logic [ADDR_W-1:0]                             a_rd_addr,
    output logic                                          w_rd_en,
    output logic [ADDR_W-1:0]                             w_rd_addr,
    output logic                                          out_wr_en,
    output logic [ADDR_W-1:0]                             out_wr_addr,
    output logic [DW*ROW_A-1:0]                           out_wr_data,
    output logic                                          wb_valid,
    output logic [((ROW_A > 1) ? $clog2(ROW_A) : 1)-1:0]  wb_idx,
    output logic [15:0]                                   tile_cnt,
    output logic                                          busy,
    output logic                                          err_len,
    output logic                                          err_overlap
);

    localparam int unsigned IW = (ROW_A > 1) ? $clog2(ROW_A) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDW, S_DRAIN, S_WB} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_base, w_base, out_addr;
    logic [CW-1:0]     a_cnt, w_cnt, o_cnt;
    logic              wb_legal_c;

    // Writeback is only allowed once a full row strip of tiles has completed.
    assign wb_legal_c = (tile_cnt % 16'(TILES_PER_ROW)) == 16'd0;

    // Operand reads are combinational so the SRAM sees the address in the strobe cycle.
    assign a_rd_en   = load_a & reset;
    assign a_rd_addr = reset ? a_base + ADDR_W'(a_cnt) : '0;
    assign w_rd_en   = load_w & reset;
    assign w_rd_addr = reset ? w_base + ADDR_W'(w_cnt) : '0;
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // The FSM always follows the most advanced strobe present, even an unexpected one.
    always_comb begin
        state_d = state_q;
        if (reset_sys)                                    state_d = S_IDLE;
        else if (deload_out)                              state_d = S_WB;
        else if (deload)                                  state_d = S_DRAIN;
        else if (load_w)                                  state_d = S_LDW;
        else if (load_a)                                  state_d = S_LDA;
        else if (state_q == S_DRAIN || state_q == S_WB)   state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_base      <= '0;
            w_base      <= '0;
            out_addr    <= '0;
            a_cnt       <= '0;
            w_cnt       <= '0;
            o_cnt       <= '0;
            tile_cnt    <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
            wb_valid    <= 1'b0;
            wb_idx      <= '0;
        end else begin
            if (compute) tile_cnt <= tile_cnt + 16'd1;

            if (reset_sys) begin
                a_base <= '0;
                w_base <= '0;
            end else if (compute) begin
                a_base <= a_base + ADDR_W'(COL_A);
                w_base <= w_base + ADDR_W'(ROW_W);
            end

            // Burst counters double as beat index; saturate so a runaway burst cannot alias a legal length.
            if (compute || !load_a)  a_cnt <= '0;
            else if (a_cnt != '1)    a_cnt <= a_cnt + CW'(1);
            if (compute || !load_w)  w_cnt <= '0;
            else if (w_cnt != '1)    w_cnt <= w_cnt + CW'(1);
            if (compute || !deload_out) o_cnt <= '0;
            else if (o_cnt != '1)       o_cnt <= o_cnt + CW'(1);

            // A store coinciding with reset_sys still writes at the pre-clear address.
            out_wr_en <= store;
            if (store) begin
                out_wr_addr <= out_addr;
                out_wr_data <= res_in;
            end
            if (reset_sys)  out_addr <= '0;
            else if (store) out_addr <= out_addr + ADDR_W'(1);

            wb_valid <= deload_out & wb_legal_c;
            wb_idx   <= (deload_out & wb_legal_c) ? IW'(o_cnt) : '0;
        end
    end

`ifdef VPU_RESP_ERRCHK_EN
    logic la_q, lw_q, do_q;
    logic ill_c, multi_c, len_bad_c, ovl_c;

    // Strobes that have no business appearing in the current phase.
    always_comb begin
        ill_c = 1'b0;
        case (state_q)
            S_IDLE:  ill_c = load_w | deload;
            S_LDA:   ill_c = deload | deload_out;
            S_LDW:   ill_c = load_a | deload_out;
            S_DRAIN: ill_c = load_a | load_w | deload_out;
            S_WB:    ill_c = load_a | load_w | deload;
            default: ill_c = 1'b0;
        endcase
    end

    assign multi_c = (load_a & load_w) | (load_a & deload) | (load_a & deload_out)
                   | (load_w & deload) | (load_w & deload_out) | (deload & deload_out);
    assign ovl_c   = multi_c | ill_c | (deload_out & ~wb_legal_c);
    assign len_bad_c = (la_q & ~load_a     & (a_cnt != CW'(COL_A)))
                     | (lw_q & ~load_w     & (w_cnt != CW'(ROW_W)))
                     | (do_q & ~deload_out & (o_cnt != CW'(ROW_A)))
                     | (compute & (load_a | load_w | deload_out));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            la_q        <= 1'b0;
            lw_q        <= 1'b0;
            do_q        <= 1'b0;
            err_len     <= 1'b0;
            err_overlap <= 1'b0;
        end else begin
            la_q        <= load_a;
            lw_q        <= load_w;
            do_q        <= deload_out;
            err_len     <= len_bad_c | (err_len & ~err_clr);
            err_overlap <= ovl_c | (err_overlap & ~err_clr);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_len        = 1'b0;
    assign err_overlap    = 1'b0;
`endif

endmodule

// File: doc/vpu_tile_responder.md
Name: vpu_tile_responder

Overview:
- Datapath-side responder to the VPU controller's strobe sequence: compute, load_a, load_w, deload, store, deload_out, reset_sys.
- Turns each strobe burst into operand-memory read addresses and result-memory write transactions.
- Checks the strobe protocol and reports violations through sticky error flags.
- Sits between the controller and the A/W operand SRAMs and the output SRAM.

Parameters:
- DW, 16, element width in bits
- ROW_A, 4, elements per result vector; also the expected length of a deload_out burst
- COL_A, 4, expected length of a load_a burst
- ROW_W, 4, expected length of a load_w burst
- ADDR_W, 10, width of every memory address
- TILES_PER_ROW, 2, tiles per output row strip (COL_N/COL_A); sets when deload_out is legal

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- compute  in  1  tile-start pulse
- load_a  in  1  A-load burst strobe
- load_w  in  1  W-load burst strobe
- deload  in  1  array drain strobe
- store  in  1  result-store strobe
- deload_out  in  1  output-writeback burst strobe
- reset_sys  in  1  end-of-strip clear pulse
- res_in  in  DW*ROW_A  result vector from the array, valid while store=1
- err_clr  in  1  clears the sticky error flags
- a_rd_en  out  1  A-SRAM read enable
- a_rd_addr  out  ADDR_W  A-SRAM read address
- w_rd_en  out  1  W-SRAM read enable
- w_rd_addr  out  ADDR_W  W-SRAM read address
- out_wr_en  out  1  output-SRAM write enable
- out_wr_addr  out  ADDR_W  output-SRAM write address
- out_wr_data  out  DW*ROW_A  output-SRAM write data
- wb_valid  out  1  writeback beat valid
- wb_idx  out  clog2(ROW_A)  writeback beat index
- tile_cnt  out  16  number of completed compute pulses
- busy  out  1  FSM not in IDLE
- err_len  out  1  sticky: burst-length mismatch
- err_overlap  out  1  sticky: illegal strobe overlap

Behaviour:
- Reset (reset=0, asynchronous): every output is 0; FSM goes to IDLE; a_base, w_base, out_addr, burst counters and tile_cnt are cleared.
- FSM states: IDLE, LDA, LDW, DRAIN, WB.
  - IDLE->LDA on load_a; LDA->LDW on load_w; LDW->DRAIN on deload; DRAIN->IDLE when deload falls.
  - IDLE->WB on deload_out; WB->IDLE when deload_out falls.
  - Any other strobe arriving in a state is recorded as err_overlap; the FSM still follows the strobe.
- compute pulse:
  - Next cycle, tile_cnt increments.
  - a_base advances by COL_A and w_base by ROW_W, both wrapping modulo 2^ADDR_W.
  - Burst counters clear.
- Read addresses:
  - In the cycle load_a is sampled high: a_rd_en=1 and a_rd_addr = a_base + burst index (index 0..COL_A-1).
  - w_rd_en and w_rd_addr behave the same way for load_w.
  - Combinational from the strobe and registered counters; zero added latency.
- Store path:
  - Each cycle store=1: res_in is registered.
  - Next cycle: out_wr_en=1, out_wr_data = registered res_in, out_wr_addr = out_addr; out_addr then increments, wrapping at 2^ADDR_W.
  - store is legal concurrently with deload; it is not an overlap error.
- Writeback:
  - Each cycle deload_out=1: wb_valid=1 and wb_idx counts 0..ROW_A-1 with one-cycle latency.
  - deload_out is legal only when tile_cnt % TILES_PER_ROW == 0; otherwise err_overlap is set and wb_valid stays 0.
- Burst length check:
  - On the falling edge of load_a, load_w or deload_out, the burst count is compared with COL_A, ROW_W or ROW_A respectively.
  - A mismatch sets err_len.
  - A burst still open when compute arrives sets err_len.
- Overlap check: err_overlap sets when two or more of load_a, load_w, deload, deload_out are high in the same cycle.
- Error clearing: err_len and err_overlap hold until err_clr=1 or reset. If a new error and err_clr=1 occur in the same cycle, set wins.
- reset_sys pulse: next cycle, out_addr, a_base and w_base return to 0 and the FSM goes to IDLE. tile_cnt and the error flags are kept. If store and reset_sys coincide, the pending write completes first and the clear takes effect after it.
- Reset mid-burst: immediate clear; no partial write is issued.

Optional Feature:
- Macro: VPU_RESP_ERRCHK_EN.
- Defined: burst-length and overlap checking logic is built in; err_len and err_overlap behave as above.
- Undefined: the checker logic is omitted; err_len and err_overlap are tied to 0; err_clr is ignored. All other behaviour is identical.

Test Plan:
- Nominal tile (defaults): compute, then load_a 4 cycles, load_w 4, deload 20, store 20 -> a_rd_addr 4..7, w_rd_addr 4..7, 20 writes to out_wr_addr 0..19, data equal to res_in delayed one cycle, no errors.
- Short burst: load_a held 3 cycles -> err_len=1 on the cycle after the falling edge; remains 1 until err_clr, then 0.
- Overlap: load_a and load_w high together for 1 cycle -> err_overlap=1; FSM in LDW.
- Writeback gating: deload_out 4 cycles at tile_cnt=1 -> wb_valid stays 0 and err_overlap=1. At tile_cnt=2 -> wb_idx 0,1,2,3 with wb_valid=1.
- Wrap and clear: ADDR_W=4, 18 store cycles -> out_wr_addr wraps 15->0. Then reset_sys -> next write lands at address 0.
- Asynchronous reset during store burst: reset=0 mid-cycle -> out_wr_en drops immediately and all outputs read 0. Build without VPU_RESP_ERRCHK_EN -> the error flags never assert.
